// File: rtl/pwm_demodulator.sv
// rtl/pwm_demodulator.sv - recovers per-symbol high-step counts from a serial PWM line
module pwm_demodulator #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] clks_per_pwm_step,
    input  logic [WIDTH-1:0] steps_per_symbol,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_valid,
    output logic             locked
);

    localparam logic [0:0]       HUNT    = 1'b0;
    localparam logic [0:0]       MEASURE = 1'b1;
    localparam logic [WIDTH-1:0] ONE     = 1;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   pwm_s;
    logic                   pwm_d;
    logic                   rise;

    logic [0:0]       state;
    logic [WIDTH-1:0] clk_cnt;
    logic [WIDTH-1:0] step_cnt;
    logic [WIDTH-1:0] high_cnt;

    logic [WIDTH-1:0] p_eff;
    logic [WIDTH-1:0] s_eff;
    logic [WIDTH-1:0] cur_clk;
    logic [WIDTH-1:0] cur_step;
    logic [WIDTH-1:0] cur_high;
    logic [WIDTH-1:0] high_next;
    logic             active;
    logic             mid;
    logic             step_end;
    logic             sym_end;

    assign pwm_s  = sync_ff[SYNC_STAGES-1];
    assign rise   = pwm_s & ~pwm_d;
    assign locked = (state == MEASURE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
            pwm_d   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], pwm_in};
            pwm_d   <= pwm_s;
        end
    end

    // The rise cycle is processed as clock 0 of step 0, so it sees zeroed counters.
    always_comb begin
        p_eff     = (clks_per_pwm_step == '0) ? ONE : clks_per_pwm_step;
        s_eff     = (steps_per_symbol == '0) ? ONE : steps_per_symbol;
        active    = enable && ((state == MEASURE) || rise);
        cur_clk   = (state == MEASURE) ? clk_cnt  : '0;
        cur_step  = (state == MEASURE) ? step_cnt : '0;
        cur_high  = (state == MEASURE) ? high_cnt : '0;
        mid       = (cur_clk == (p_eff >> 1));
        // >= rather than == keeps the counters bounded if config shrinks mid-symbol
        step_end  = (cur_clk >= (p_eff - ONE));
        sym_end   = step_end && (cur_step >= (s_eff - ONE));
        high_next = cur_high;
        if (mid && pwm_s && (cur_high != '1)) begin
            high_next = cur_high + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            clk_cnt      <= '0;
            step_cnt     <= '0;
            high_cnt     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!active) begin
                state    <= HUNT;
                clk_cnt  <= '0;
                step_cnt <= '0;
                high_cnt <= '0;
            end else if (sym_end) begin
                sample_out   <= high_next;
                sample_valid <= 1'b1;
                clk_cnt      <= '0;
                step_cnt     <= '0;
                high_cnt     <= '0;
                // A high line at symbol end means the next symbol has no rising edge.
                state        <= pwm_s ? MEASURE : HUNT;
            end else begin
                state    <= MEASURE;
                high_cnt <= high_next;
                if (step_end) begin
                    clk_cnt  <= '0;
                    step_cnt <= cur_step + ONE;
                end else begin
                    clk_cnt  <= cur_clk + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_demodulator.sv
// tb/tb_pwm_demodulator.sv - self-checking bench for pwm_demodulator
module tb_pwm_demodulator;

    localparam int SYNC = 2;
    localparam int W    = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] cfg_p = '0;
    logic [W-1:0] cfg_s = '0;
    logic         pwm_in = 1'b0;
    logic [W-1:0] sample_out;
    logic         sample_valid;
    logic         locked;

    pwm_demodulator #(.SYNC_STAGES(SYNC), .WIDTH(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .clks_per_pwm_step (cfg_p),
        .steps_per_symbol  (cfg_s),
        .pwm_in            (pwm_in),
        .sample_out        (sample_out),
        .sample_valid      (sample_valid),
        .locked            (locked)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic hist [0:SYNC];
    bit   m_active = 0;
    int   m_k = 0;
    int   m_high = 0;
    int   m_sample = 0;
    bit   m_valid = 0;

    typedef struct {
        int p;
        int s;
        int hi;
        int period;
        int nsym;
        int exp_sample;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: position k within the symbol; step = k / P, midpoint when k % P == P/2.
    task automatic cyc(input logic r, input logic e, input logic p);
        bit s_m;
        bit rise_m;
        int pp;
        int ss;
        s_m    = hist[SYNC-1];
        rise_m = hist[SYNC-1] && !hist[SYNC];
        pp     = (cfg_p == 0) ? 1 : int'(cfg_p);
        ss     = (cfg_s == 0) ? 1 : int'(cfg_s);
        m_valid = 0;
        if (r) begin
            m_active = 0; m_k = 0; m_high = 0; m_sample = 0;
        end else if (!e) begin
            m_active = 0;
        end else if (m_active || rise_m) begin
            if (!m_active) begin
                m_active = 1; m_k = 0; m_high = 0;
            end
            if ((m_k % pp) == pp / 2 && s_m && m_high < (1 << W) - 1) m_high++;
            if (m_k == pp * ss - 1) begin
                m_valid  = 1;
                m_sample = m_high;
                m_active = s_m;
                m_k = 0;
                m_high = 0;
            end else begin
                m_k++;
            end
        end
        if (r) begin
            for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
        end else begin
            for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = p;
        end
        rst = r;
        enable = e;
        pwm_in = p;
        @(posedge clk);
        #1;
        checks++;
        if (sample_valid !== m_valid || locked !== m_active || sample_out !== m_sample[W-1:0]) begin
            errors++;
            $display("FAIL model: got valid=%0b locked=%0b sample=%0d expected valid=%0b locked=%0b sample=%0d",
                     sample_valid, locked, sample_out, m_valid, m_active, m_sample);
        end
    endtask

    initial begin
        int  vcnt;
        int  bad;
        bit  pin;
        int  run;
        bit  en;
        bit  seen;

        for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
        tbl[0] = '{4, 8, 12, 32, 4, 3};
        tbl[1] = '{4, 8, 32, 32, 3, 8};
        tbl[2] = '{5, 3, 8, 15, 5, 2};
        tbl[3] = '{3, 4, 6, 12, 5, 2};
        tbl[4] = '{2, 5, 6, 10, 6, 3};

        // reset state
        cfg_p = 8'd4; cfg_s = 8'd8;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("reset_sample", int'(sample_out), 0);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_locked", int'(locked), 0);

        // reset in the middle of a symbol
        for (int i = 0; i < 4; i++) cyc(0, 1, 0);
        for (int i = 0; i < 14; i++) cyc(0, 1, 1);
        chk("midsym_locked", int'(locked), 1);
        cyc(1, 1, 1);
        chk("midsym_rst_sample", int'(sample_out), 0);
        chk("midsym_rst_locked", int'(locked), 0);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 1, 0);
            if (sample_valid) vcnt++;
        end
        chk("midsym_no_valid", vcnt, 0);

        // table-driven periodic patterns
        for (int t = 0; t < 5; t++) begin
            cfg_p = W'(tbl[t].p);
            cfg_s = W'(tbl[t].s);
            cyc(1, 0, 0);
            cyc(1, 0, 0);
            for (int i = 0; i < 4; i++) cyc(0, 1, 0);
            vcnt = 0;
            bad = 0;
            for (int c = 0; c < tbl[t].nsym * tbl[t].period + 6; c++) begin
                pin = (c % tbl[t].period) < tbl[t].hi;
                cyc(0, (c < tbl[t].nsym * tbl[t].period + 3), pin);
                if (sample_valid) begin
                    vcnt++;
                    if (int'(sample_out) != tbl[t].exp_sample) bad++;
                end
            end
            chk($sformatf("tbl%0d_valid_count", t), vcnt, tbl[t].nsym);
            chk($sformatf("tbl%0d_bad_samples", t), bad, 0);
        end

        // zero duty: no carrier for 1000 clocks
        vcnt = 0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(0, 1, 0);
            if (sample_valid) vcnt++;
            if (locked || sample_out != 8'd3) bad++;
        end
        chk("zero_duty_valids", vcnt, 0);
        chk("zero_duty_locked_or_sample", bad, 0);

        // degenerate configuration: P=0, S=1
        cfg_p = 8'd0; cfg_s = 8'd1;
        cyc(0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        chk("degen_early_valid", int'(sample_valid), 0);
        cyc(0, 1, 0);
        chk("degen_valid", int'(sample_valid), 1);
        chk("degen_sample", int'(sample_out), 1);
        for (int i = 0; i < 6; i++) cyc(0, 1, i % 2);

        // enable drop mid-symbol
        cfg_p = 8'd4; cfg_s = 8'd8;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 1);
        chk("endrop_locked_before", int'(locked), 1);
        cyc(0, 0, 1);
        chk("endrop_locked_after", int'(locked), 0);
        chk("endrop_valid", int'(sample_valid), 0);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 1, 1);
            if (sample_valid) vcnt++;
        end
        chk("endrop_no_valid", vcnt, 0);

        // saturation boundary: S=255, continuous high
        cfg_p = 8'd1; cfg_s = 8'd255;
        cyc(0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cyc(0, 1, 1);
            if (sample_valid) seen = 1;
        end
        chk("sat_seen_valid", int'(seen), 1);
        chk("sat_sample", int'(sample_out), 255);
        cyc(0, 0, 0);

        // randomized runs against the reference model
        for (int r = 0; r < 8; r++) begin
            cfg_p = W'($urandom_range(0, 6));
            cfg_s = W'($urandom_range(0, 6));
            cyc(0, 0, 0);
            cyc(0, 0, 0);
            run = 0;
            pin = 0;
            for (int i = 0; i < 600; i++) begin
                if (run == 0) begin
                    pin = ~pin;
                    run = $urandom_range(1, 12);
                end
                run--;
                en = ($urandom_range(0, 99) != 0);
                cyc(0, en, pin);
            end
            cyc(0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_demodulator.md
Name: pwm_demodulator

Overview:
- Receive-side counterpart of the AM PWM modulator: recovers 8-bit samples from a serial PWM line.
- The incoming line is synchronised and aligned on the rising edge that starts each PWM symbol.
- Each step is sampled at its midpoint, and high steps are counted per symbol.
- One sample per symbol is emitted with a single-cycle valid strobe.
- Used in loopback/self-test paths and for receive-side PWM links.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the pwm_in synchroniser (minimum 2).
- WIDTH, 8, width of step/symbol counters, configuration inputs and sample_out.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  demodulator enable; low forces HUNT and suppresses output.
- clks_per_pwm_step  input  WIDTH  clocks per PWM step; 0 is treated as 1.
- steps_per_symbol  input  WIDTH  PWM steps per symbol; 0 is treated as 1.
- pwm_in  input  1  asynchronous serial PWM line.
- sample_out  output  WIDTH  recovered sample, i.e. the count of high steps in the last symbol.
- sample_valid  output  1  one-cycle strobe; sample_out is valid in the same cycle.
- locked  output  1  high while in MEASURE state.

Behaviour:
- Reset: sample_out=0, sample_valid=0, locked=0, state=HUNT, all counters 0, synchroniser flops 0.
- Synchroniser:
  - pwm_in passes through SYNC_STAGES flops to give pwm_s.
  - pwm_d holds pwm_s delayed one clock.
  - rise = pwm_s & ~pwm_d.
- Configuration values are read every cycle. Changing them mid-symbol is not supported (the result is undefined, but the FSM must not hang).
- Step counter:
  - clk_cnt counts 0..P-1, where P = max(clks_per_pwm_step, 1).
  - mid tick when clk_cnt == P>>1.
  - step_end tick when clk_cnt == P-1; clk_cnt then wraps to 0.
  - With P=1, mid and step_end occur in every cycle.
- Symbol counter: step_cnt counts 0..S-1, where S = max(steps_per_symbol, 1); it advances on step_end.
- FSM HUNT:
  - Counters are held at 0; locked=0.
  - On rise with enable=1: go to MEASURE. clk_cnt=1 and step_cnt=0 in the next cycle (the rise cycle counts as clock 0 of step 0). high_cnt=0.
- FSM MEASURE:
  - locked=1.
  - On mid, if pwm_s=1, high_cnt += 1, saturating at 2^WIDTH-1.
  - On step_end with step_cnt == S-1 (end of symbol):
    - Next cycle: sample_out = final high_cnt, including any increment in this same cycle when mid and step_end coincide. sample_valid=1 for exactly that cycle.
    - If pwm_s=1 at end of symbol: stay in MEASURE and restart counters at 0. This handles full duty / back-to-back symbols with no rising edge.
    - Otherwise return to HUNT.
- Rise in MEASURE before the end of symbol is ignored (no resync mid-symbol).
- enable=0:
  - Go to HUNT next cycle and clear counters.
  - No sample_valid is generated; a symbol in progress is discarded.
  - sample_out holds its last value.
- Latency:
  - pwm_in edge to rise takes SYNC_STAGES+1 clocks.
  - sample_valid asserts 1 clock after the last step_end of the symbol.
- sample_out only changes when sample_valid=1 (or on reset).
- Symbol timing is identical to the modulator: a modulator sample value v produces v+1 high steps, so recovered sample_out = v+1. Software subtracts 1; this block does not.
- Size: roughly 150-250 lines of RTL (synchroniser, two counters, FSM, saturating accumulator).

Test Plan:
- Reset mid-symbol: P=4, S=8, drive pwm high 3 steps then assert rst for 1 cycle -> all outputs 0, state HUNT, no sample_valid until the next rise plus a full symbol.
- Basic duty: P=4, S=8, pwm high 3 steps (12 clks) then low 5 steps, repeated -> sample_valid once per 32 clks, sample_out=3, locked=1 during each symbol.
- Full duty: P=4, S=8, pwm constantly high after one rise -> FSM stays in MEASURE, sample_out=8 every 32 clks with no gaps.
- Zero duty / no carrier: pwm held low for 1000 clks -> no sample_valid, locked=0, sample_out unchanged.
- Degenerate config: P=0, S=1, pwm high 1 clk and low 1 clk -> P and S treated as 1. Each rise yields sample_out=1, sample_valid one clock after the symbol end.
- Enable drop and saturation:
  - Deassert enable mid-symbol -> no strobe, locked=0 next cycle.
  - With WIDTH=8, S=255 and continuous high -> sample_out=255 (saturated), no wrap.
